// File: rtl/morse_pkg.sv
// morse_pkg: shared state encoding, morse symbol codes and code width for the morse game
package morse_pkg;
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_P1_ENTRY  = 3'd1,
        S_ARM       = 3'd2,
        S_P2_GUESS  = 3'd3,
        S_WIN       = 3'd4,
        S_LOSE      = 3'd5,
        S_GAME_OVER = 3'd6
    } state_t;
    localparam logic [1:0] MORSE_NONE = 2'b00;
    localparam logic [1:0] MORSE_DOT  = 2'b01;
    localparam logic [1:0] MORSE_LINE = 2'b11;
    localparam int CODE_W = 10;
endpackage

// File: rtl/morse_round_timer.sv
// round_timer: 8-bit loadable down-counter that flags expiry on the tick that leaves value 1
module round_timer (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_value,
    input  logic       tick,
    output logic [7:0] value,
    output logic       expire
);
    assign expire = tick && value == 8'd1;
    always_ff @(posedge clock) begin
        if (reset) value <= '0;
        else if (load) value <= load_value;
        else if (tick && value != '0) value <= value - 8'd1;
    end
endmodule

// File: rtl/morse_round_controller.sv
// morse_round_controller: sequences code entry, guessing, timeout and scoring for the morse game
module morse_round_controller #(
    parameter int CODE_W       = 10,
    parameter int TIME_LIMIT   = 30,
    parameter int MAX_ATTEMPTS = 3,
    parameter int NUM_ROUNDS   = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              tick,
    input  logic              p1_done,
    input  logic [CODE_W-1:0] p1_code,
    input  logic              p2_complete,
    input  logic              p2_error,
    output logic              p1_enable,
    output logic              p2_enable,
    output logic              p2_clear,
    output logic [CODE_W-1:0] target_code,
    output logic [7:0]        time_left,
    output logic [1:0]        attempts_left,
    output logic [3:0]        round,
    output logic [3:0]        score_p1,
    output logic [3:0]        score_p2,
    output logic [2:0]        state,
    output logic              game_over
);
    import morse_pkg::*;
    state_t cur, nxt;
    logic guess, win_ev, err_ev, fatal_err, tick_ev, expire, lose_ev, new_game;
    assign guess     = cur == S_P2_GUESS;
    assign win_ev    = guess && p2_complete;
    assign err_ev    = guess && !p2_complete && p2_error;
    assign fatal_err = err_ev && attempts_left == 2'd1;
    // a fatal error ends the round, so the same-cycle tick must not also count
    assign tick_ev   = guess && !p2_complete && !fatal_err && tick;
    assign lose_ev   = fatal_err || expire;
    assign new_game  = (cur == S_IDLE || cur == S_GAME_OVER) && start;
    assign state     = cur;
    round_timer u_timer (
        .clock(clock),
        .reset(reset),
        .load(cur == S_ARM),
        .load_value(8'(TIME_LIMIT)),
        .tick(tick_ev),
        .value(time_left),
        .expire(expire)
    );
    always_comb begin
        nxt = cur;
        case (cur)
            S_IDLE:       nxt = start ? S_P1_ENTRY : S_IDLE;
            S_P1_ENTRY:   nxt = (p1_done && p1_code != '0) ? S_ARM : S_P1_ENTRY;
            S_ARM:        nxt = S_P2_GUESS;
            S_P2_GUESS:   nxt = win_ev ? S_WIN : lose_ev ? S_LOSE : S_P2_GUESS;
            S_WIN, S_LOSE: nxt = !start ? cur : (round == 4'(NUM_ROUNDS)) ? S_GAME_OVER : S_P1_ENTRY;
            S_GAME_OVER:  nxt = start ? S_P1_ENTRY : S_GAME_OVER;
            default:      nxt = S_IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            cur           <= S_IDLE;
            p1_enable     <= 1'b0;
            p2_enable     <= 1'b0;
            p2_clear      <= 1'b0;
            game_over     <= 1'b0;
            target_code   <= '0;
            attempts_left <= '0;
            round         <= '0;
            score_p1      <= '0;
            score_p2      <= '0;
        end else begin
            cur       <= nxt;
            p1_enable <= nxt == S_P1_ENTRY;
            p2_enable <= nxt == S_P2_GUESS;
            p2_clear  <= nxt == S_ARM || (err_ev && !fatal_err);
            game_over <= nxt == S_GAME_OVER;
            if (cur == S_P1_ENTRY && nxt == S_ARM) target_code <= p1_code;
            if (cur == S_ARM) attempts_left <= 2'(MAX_ATTEMPTS);
            else if (err_ev && attempts_left != '0) attempts_left <= attempts_left - 2'd1;
            if (new_game) begin
                round    <= '0;
                score_p1 <= '0;
                score_p2 <= '0;
            end
            if (win_ev || lose_ev) round <= round + 4'd1;
            if (win_ev && score_p2 != 4'hF) score_p2 <= score_p2 + 4'd1;
            if (!win_ev && lose_ev && score_p1 != 4'hF) score_p1 <= score_p1 + 4'd1;
        end
    end
endmodule

// File: tb/tb_morse_round_controller.sv
// tb_morse_round_controller: directed checks of round flow, attempts, timeout, game end and reset
module tb_morse_round_controller;
    localparam logic [2:0] IDLE = 3'd0, P1 = 3'd1, ARM = 3'd2, GUESS = 3'd3,
                           WIN = 3'd4, LOSE = 3'd5, GOVER = 3'd6;
    logic clock = 1'b0, reset = 1'b0, start = 1'b0, tick = 1'b0;
    logic p1_done = 1'b0, p2_complete = 1'b0, p2_error = 1'b0;
    logic [9:0] p1_code = '0;
    logic p1_enable, p2_enable, p2_clear, game_over;
    logic [9:0] target_code;
    logic [7:0] time_left;
    logic [1:0] attempts_left;
    logic [3:0] round, score_p1, score_p2;
    logic [2:0] state;
    int checks = 0, errors = 0;
    morse_round_controller #(.CODE_W(10), .TIME_LIMIT(30), .MAX_ATTEMPTS(3), .NUM_ROUNDS(2)) dut (
        .clock(clock), .reset(reset), .start(start), .tick(tick),
        .p1_done(p1_done), .p1_code(p1_code), .p2_complete(p2_complete), .p2_error(p2_error),
        .p1_enable(p1_enable), .p2_enable(p2_enable), .p2_clear(p2_clear),
        .target_code(target_code), .time_left(time_left), .attempts_left(attempts_left),
        .round(round), .score_p1(score_p1), .score_p2(score_p2), .state(state), .game_over(game_over)
    );
    always #5 clock = ~clock;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clock);
        #1;
    endtask
    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask
    task automatic do_tick();
        tick = 1'b1; step(); tick = 1'b0; step();
    endtask
    task automatic enter_code(input logic [9:0] c);
        p1_code = c; p1_done = 1'b1; step(); p1_done = 1'b0; p1_code = '0;
        step();
    endtask
    initial begin
        reset = 1'b1; step(); step(); reset = 1'b0;
        check("rst_state", state, IDLE);
        check("rst_time", time_left, 0);
        check("rst_p1en", p1_enable, 0);
        check("rst_target", target_code, 0);
        check("rst_gover", game_over, 0);
        pulse_start();
        check("p1_state", state, P1);
        check("p1_en", p1_enable, 1);
        p1_done = 1'b1; step(); p1_done = 1'b0;
        check("zero_code_state", state, P1);
        check("zero_code_target", target_code, 0);
        p1_code = 10'b0101110000; p1_done = 1'b1; step(); p1_done = 1'b0; p1_code = '0;
        check("arm_state", state, ARM);
        check("arm_target", target_code, 10'b0101110000);
        check("arm_clear", p2_clear, 1);
        check("arm_p2en", p2_enable, 0);
        step();
        check("guess_state", state, GUESS);
        check("guess_clear", p2_clear, 0);
        check("guess_p2en", p2_enable, 1);
        check("guess_time", time_left, 30);
        check("guess_att", attempts_left, 3);
        p2_complete = 1'b1; step(); p2_complete = 1'b0;
        check("win_state", state, WIN);
        check("win_score2", score_p2, 1);
        check("win_round", round, 1);
        check("win_p2en", p2_enable, 0);
        pulse_start();
        check("win_to_p1", state, P1);
        enter_code(10'b1101010000);
        for (int i = 0; i < 2; i++) begin
            p2_error = 1'b1; step(); p2_error = 1'b0;
            check("err_att", attempts_left, 2 - i);
            check("err_clear", p2_clear, 1);
            check("err_state", state, GUESS);
            step();
            check("err_clear_end", p2_clear, 0);
        end
        p2_error = 1'b1; step(); p2_error = 1'b0;
        check("err3_state", state, LOSE);
        check("err3_score1", score_p1, 1);
        check("err3_round", round, 2);
        check("err3_clear", p2_clear, 0);
        pulse_start();
        check("gover_state", state, GOVER);
        check("gover_flag", game_over, 1);
        pulse_start();
        check("ng_state", state, P1);
        check("ng_round", round, 0);
        check("ng_score1", score_p1, 0);
        check("ng_score2", score_p2, 0);
        check("ng_gover", game_over, 0);
        enter_code(10'b0100000000);
        p2_error = 1'b1; tick = 1'b1; step(); p2_error = 1'b0; tick = 1'b0;
        check("errtick_att", attempts_left, 2);
        check("errtick_time", time_left, 29);
        for (int i = 0; i < 28; i++) do_tick();
        check("tick_down_1", time_left, 1);
        p2_complete = 1'b1; tick = 1'b1; step(); p2_complete = 1'b0; tick = 1'b0;
        check("cpl_tick_state", state, WIN);
        check("cpl_tick_score2", score_p2, 1);
        check("cpl_tick_score1", score_p1, 0);
        pulse_start();
        enter_code(10'b1111000000);
        for (int i = 1; i < 30; i++) begin
            do_tick();
            check("timeout_count", time_left, 30 - i);
        end
        check("pre_timeout_state", state, GUESS);
        do_tick();
        check("timeout_state", state, LOSE);
        check("timeout_score1", score_p1, 1);
        check("timeout_time", time_left, 0);
        pulse_start();
        check("gover2_state", state, GOVER);
        pulse_start();
        enter_code(10'b0111000000);
        for (int i = 0; i < 18; i++) do_tick();
        check("pre_reset_time", time_left, 12);
        reset = 1'b1; step(); reset = 1'b0;
        check("mid_rst_state", state, IDLE);
        check("mid_rst_time", time_left, 0);
        check("mid_rst_att", attempts_left, 0);
        check("mid_rst_p2en", p2_enable, 0);
        check("mid_rst_p1en", p1_enable, 0);
        check("mid_rst_target", target_code, 0);
        check("mid_rst_round", round, 0);
        check("mid_rst_score2", score_p2, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
